// File: rtl/box_drawer.sv
// box_drawer: rasterises valid/ready box commands into one pixel plot per clock.
// Optional screen-edge clipping is enabled by defining BOX_DRAWER_CLIP_EN.
module box_drawer #(
  parameter logic [8:0] SCREEN_WIDTH  = 9'd320,
  parameter logic [8:0] SCREEN_HEIGHT = 9'd240
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [8:0] in_box_x,
  input  logic [8:0] in_box_y,
  input  logic [8:0] in_box_w,
  input  logic [8:0] in_box_h,
  input  logic [2:0] in_box_color,
  output logic       plot,
  output logic [8:0] out_x,
  output logic [8:0] out_y,
  output logic [2:0] out_color,
  output logic       busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DRAW = 1'b1
  } state_t;

  state_t     state;
  state_t     state_d;

  logic [8:0] box_x;
  logic [8:0] box_y;
  logic [8:0] box_w;
  logic [8:0] box_h;
  logic [2:0] box_color;
  logic [8:0] col;
  logic [8:0] row;

  logic [9:0] sum_x;
  logic [9:0] sum_y;
  logic       last_col;
  logic       last_row;
  logic       take;
  logic       in_view;

  assign sum_x    = {1'b0, box_x} + {1'b0, col};
  assign sum_y    = {1'b0, box_y} + {1'b0, row};
  assign last_col = (col == box_w - 9'd1);
  assign last_row = (row == box_h - 9'd1);
  assign take     = (state == S_IDLE) && s_valid;

`ifdef BOX_DRAWER_CLIP_EN
  assign in_view  = (sum_x < {1'b0, SCREEN_WIDTH}) &&
                    (sum_y < {1'b0, SCREEN_HEIGHT});
`else
  assign in_view  = 1'b1;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Command latch and raster counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      box_x     <= '0;
      box_y     <= '0;
      box_w     <= '0;
      box_h     <= '0;
      box_color <= '0;
      col       <= '0;
      row       <= '0;
    end else if (take) begin
      box_x     <= in_box_x;
      box_y     <= in_box_y;
      box_w     <= in_box_w;
      box_h     <= in_box_h;
      box_color <= in_box_color;
      col       <= '0;
      row       <= '0;
    end else if (state == S_DRAW) begin
      if (last_col) begin
        col <= '0;
        row <= row + 9'd1;
      end else begin
        col <= col + 9'd1;
      end
    end
  end

  // Next state and pixel outputs, decoded straight from the registers.
  always_comb begin
    state_d   = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    plot      = 1'b0;
    out_x     = '0;
    out_y     = '0;
    out_color = '0;
    unique case (state)
      S_IDLE: begin
        s_ready = 1'b1;
        if (s_valid && (in_box_w != '0) && (in_box_h != '0))
          state_d = S_DRAW;
      end
      S_DRAW: begin
        busy      = 1'b1;
        plot      = in_view;
        out_x     = sum_x[8:0];
        out_y     = sum_y[8:0];
        out_color = box_color;
        if (last_col && last_row)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_box_drawer.sv
// tb_box_drawer: scoreboard bench for box_drawer.
// Expected pixels are queued at command time and popped on each plot.
module tb_box_drawer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [8:0] in_box_x = '0;
  logic [8:0] in_box_y = '0;
  logic [8:0] in_box_w = '0;
  logic [8:0] in_box_h = '0;
  logic [2:0] in_box_color = '0;
  logic       plot;
  logic [8:0] out_x;
  logic [8:0] out_y;
  logic [2:0] out_color;
  logic       busy;

  int total = 0;
  int bad = 0;
  int plot_cnt = 0;
  logic [20:0] exp_q[$];

  box_drawer dut (
    .clock(clock),
    .reset_n(reset_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .in_box_x(in_box_x),
    .in_box_y(in_box_y),
    .in_box_w(in_box_w),
    .in_box_h(in_box_h),
    .in_box_color(in_box_color),
    .plot(plot),
    .out_x(out_x),
    .out_y(out_y),
    .out_color(out_color),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic push_box(input int x, input int y, input int w,
                          input int h, input int c);
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        int px;
        int py;
        logic [8:0] tx;
        logic [8:0] ty;
        logic [2:0] tc;
        px = x + k;
        py = y + r;
`ifdef BOX_DRAWER_CLIP_EN
        if (px >= 320 || py >= 240) continue;
`endif
        tx = px[8:0];
        ty = py[8:0];
        tc = c[2:0];
        exp_q.push_back({tx, ty, tc});
      end
    end
  endtask

  task automatic drive(input int x, input int y, input int w,
                       input int h, input int c);
    in_box_x = x[8:0];
    in_box_y = y[8:0];
    in_box_w = w[8:0];
    in_box_h = h[8:0];
    in_box_color = c[2:0];
    push_box(x, y, w, h, c);
  endtask

  task automatic send(input int x, input int y, input int w,
                      input int h, input int c);
    @(negedge clock);
    chk("ready_before_send", s_ready, 1);
    s_valid = 1'b1;
    drive(x, y, w, h, c);
    @(posedge clock);
    #1 s_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (s_ready) return;
      n++;
    end
    chk("timeout_busy", 1, 0);
  endtask

  always @(negedge clock) begin
    if (plot) begin
      plot_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_plot", plot, 0);
      end else begin
        chk("pixel", {out_x, out_y, out_color}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    int p0;
    #1;
    chk("rst_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_plot", plot, 0);
    chk("rst_out", {out_x, out_y, out_color}, 0);
    #20 reset_n = 1'b1;

    // basic box
    p0 = plot_cnt;
    send(5, 7, 3, 2, 5);
    #1 chk("busy_drawing", busy, 1);
    count_busy(n);
    chk("basic_cycles", n, 6);
    chk("basic_plots", plot_cnt - p0, 6);
    chk("basic_busy_after", busy, 0);

    // zero-size commands
    p0 = plot_cnt;
    send(10, 10, 0, 4, 2);
    count_busy(n);
    chk("zero_w_cycles", n, 0);
    chk("zero_w_busy", busy, 0);
    send(10, 10, 4, 0, 2);
    count_busy(n);
    chk("zero_h_cycles", n, 0);
    repeat (2) @(negedge clock);
    chk("zero_plots", plot_cnt - p0, 0);

    // screen-edge box
    p0 = plot_cnt;
    send(318, 239, 4, 2, 7);
    count_busy(n);
    chk("clip_cycles", n, 8);
`ifdef BOX_DRAWER_CLIP_EN
    chk("clip_plots", plot_cnt - p0, 2);
`else
    chk("clip_plots", plot_cnt - p0, 8);
`endif

    // new command held valid while busy
    @(negedge clock);
    s_valid = 1'b1;
    drive(40, 20, 2, 2, 3);
    @(posedge clock);
    #1 drive(100, 50, 2, 2, 4);
    count_busy(n);
    chk("hold_wait", n, 4);
    @(posedge clock);
    #1 s_valid = 1'b0;
    count_busy(n);
    chk("hold_second", n, 4);

    // background then paddle, back to back
    p0 = plot_cnt;
    @(negedge clock);
    s_valid = 1'b1;
    drive(0, 0, 8, 6, 0);
    @(posedge clock);
    #1 drive(1, 1, 2, 3, 6);
    count_busy(n);
    chk("bg_cycles", n, 48);
    @(posedge clock);
    #1 s_valid = 1'b0;
    count_busy(n);
    chk("paddle_cycles", n, 6);
    chk("integ_plots", plot_cnt - p0, 54);

    // reset mid-draw
    p0 = plot_cnt;
    send(20, 30, 4, 4, 6);
    for (int i = 0; i < 100 && plot_cnt - p0 < 3; i++)
      @(negedge clock);
    chk("mid_plots", plot_cnt - p0, 3);
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_plot", plot, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", s_ready, 1);
    chk("async_out", {out_x, out_y, out_color}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    p0 = plot_cnt;
    send(9, 9, 2, 1, 2);
    count_busy(n);
    chk("after_rst_cycles", n, 2);
    chk("after_rst_plots", plot_cnt - p0, 2);

    repeat (3) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/box_drawer.md
# box_drawer

Consumes box-draw commands from `screenDrawer` through a valid/ready handshake and rasterises each box into one pixel write per clock for the VGA adapter's plot interface. Each accepted box is walked in raster order: row by row, left to right within a row. It sits directly downstream of `screenDrawer`, between that block's `m_valid`/`m_ready` port and the VGA adapter.

## Interface
Parameters:
- `SCREEN_WIDTH`, default 9'd320: horizontal clip limit in pixels.
- `SCREEN_HEIGHT`, default 9'd240: vertical clip limit in pixels.

Ports:
- `clock`, input, 1: the single clock.
- `reset_n`, input, 1: reset, asynchronous and active-low.
- `s_valid`, input, 1: box command valid; wired to `screenDrawer.m_valid`.
- `s_ready`, output, 1: block can accept a command; wired to `screenDrawer.m_ready`.
- `in_box_x`, input, 9: box left edge.
- `in_box_y`, input, 9: box top edge.
- `in_box_w`, input, 9: box width in pixels.
- `in_box_h`, input, 9: box height in pixels.
- `in_box_color`, input, 3: fill colour.
- `plot`, output, 1: pixel write strobe to the VGA adapter.
- `out_x`, output, 9: pixel column.
- `out_y`, output, 9: pixel row.
- `out_color`, output, 3: pixel colour.
- `busy`, output, 1: high while a box is being drawn.

## Operation
- States: `S_IDLE`, `S_DRAW`.
- **S_IDLE**
  - `s_ready`=1; `busy`=0; `plot`=0.
  - `out_x`, `out_y`, `out_color` = 0.
  - A transfer occurs on a rising edge when `s_valid` && `s_ready`. On transfer, latch x, y, w, h and color, and clear column counter `col` and row counter `row`.
  - If the transferred w==0 or h==0, the command is consumed as a no-op and the block stays in `S_IDLE`.
  - Otherwise the next state is `S_DRAW`.
- **S_DRAW**
  - `s_ready`=0; `busy`=1; `s_valid` is ignored.
  - `out_x` = x+col and `out_y` = y+row, each computed in 10 bits and truncated to 9 for the port. `out_color` = the latched color.
  - Each cycle: if col==w-1, then col←0 and row←row+1; otherwise col←col+1.
  - When col==w-1 and row==h-1, the next state is `S_IDLE`.
- `plot` is decoded combinationally from state, counters and clip; there are no extra register stages on the pixel path.
- Counters are 9 bits; w and h up to 511 are legal.
- Reset, asserted at any time including mid-box:
  - State goes to `S_IDLE` immediately and counters and latches clear.
  - Outputs take their reset values asynchronously: `s_ready`=1, `busy`=0, `plot`=0, `out_x`=0, `out_y`=0, `out_color`=0.
  - The partially drawn box is abandoned and not resumed.

## Timing
- Transfer at edge k → first pixel (col=0, row=0) presented with `plot` during cycle k+1.
- A w×h box occupies exactly w·h cycles in `S_DRAW`, one pixel per cycle with no bubbles. This holds even for clipped pixels.
- `s_ready` rises in cycle k+1+w·h. The earliest next transfer is at the end of that cycle.
- A full-screen clear (320×240) takes 76800 cycles, comfortably below the 833332-cycle refresh interval in `screenDrawer`.
- A zero-size command costs one cycle; `s_ready` stays high throughout.

## Configuration
- Macro: `BOX_DRAWER_CLIP_EN`.
- When defined:
  - `plot`=0 for any pixel whose 10-bit x+col ≥ `SCREEN_WIDTH` or y+row ≥ `SCREEN_HEIGHT`.
  - Clipped pixels still consume their cycle, so timing is unchanged.
- When undefined:
  - `plot`=1 for every pixel in `S_DRAW`.
  - Coordinates wrap modulo 512, i.e. the 9-bit truncation.

## Test plan
- **Basic box.** After reset, send x=5, y=7, w=3, h=2, color=3'b101.
  - Exactly 6 plots, in order: (5,7), (6,7), (7,7), (5,8), (6,8), (7,8), each with colour 5.
  - `s_ready` low for 6 cycles, then high.
- **Zero size.** Send w=0, h=4, then w=4, h=0.
  - No `plot` pulses; `s_ready` never drops; `busy` stays 0.
- **Clip (macro defined).** Send x=318, y=239, w=4, h=2.
  - 8 draw cycles; `plot` only at (318,239) and (319,239).
  - Macro undefined: 8 plots, with `out_x` reaching 320 and 321.
- **Busy ignore.** Hold `s_valid`=1 with new data (x=100) throughout a 2×2 box.
  - The second command is accepted only in the cycle `s_ready` returns.
  - The first box's pixels are unaffected.
- **Integration with `screenDrawer`.** Use small screen parameters, 8×6 with a 2×3 paddle at (1,1).
  - Background produces 48 plots of colour 0, immediately followed by 6 plots of the paddle colour.
- **Reset mid-draw.** Assert `reset_n`=0 after the 3rd pixel of a 4×4 box.
  - `plot`, `busy`, `out_x`, `out_y` and `out_color` drop to 0 and `s_ready` rises to 1 without waiting for a clock edge.
  - After release, a new box draws from its (0,0) offset.
